// File: rtl/carregador_matriz_5x5_if.sv
// Stream-in / matrix-out handshake bundle for the 5x5 matrix loader.
//   slave  : the loader (consumes the element stream, produces the matrix)
//   master : the environment (drives the element stream, consumes the matrix)
// Signals: in_valid/in_ready/in_data/in_last (element stream),
//          mat_valid/mat_ready/matriz_5x5 (packed matrix handshake).
interface carregador_matriz_5x5_if #(
  parameter int W     = 8,
  parameter int NELEM = 25
);
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic                 in_last;
  logic                 mat_valid;
  logic                 mat_ready;
  logic [NELEM*W-1:0]   matriz_5x5;

  modport slave (
    input  in_valid, in_data, in_last, mat_ready,
    output in_ready, mat_valid, matriz_5x5
  );

  modport master (
    output in_valid, in_data, in_last, mat_ready,
    input  in_ready, mat_valid, matriz_5x5
  );
endinterface

// File: rtl/carregador_matriz_5x5.sv
// carregador_matriz_5x5: assembles a row-major stream of W-bit elements into
// a packed NELEM*W-bit matrix. Element 0 ends up in the top byte lane, the
// last element in bits [W-1:0]. Single-buffered: the stream stalls while a
// full matrix waits for the consumer.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   limpa        : synchronous abort of the partial/held matrix
//   bus (slave)  : element stream in, matrix handshake out
//   elem_cnt     : elements accepted in the current frame (0..24)
//   erro_quadro  : one-cycle framing error pulse
// Optional feature: define CARREGADOR_CHECA_LAST_EN to check in_last framing;
// otherwise in_last is ignored and erro_quadro is tied to 0.
module carregador_matriz_5x5 #(
  parameter int W     = 8,
  parameter int NELEM = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     limpa,
  carregador_matriz_5x5_if.slave   bus,
  output logic [4:0]               elem_cnt,
  output logic                     erro_quadro
);

  typedef enum logic {CARGA = 1'b0, CHEIO = 1'b1} estado_t;

  localparam logic [4:0] ULT = 5'(NELEM - 1);

  estado_t              estado, estado_n;
  logic [4:0]           cnt_n;
  logic [NELEM*W-1:0]   mat_q, mat_n;
  logic                 aceita;
  logic                 erro_n;
  logic                 erro_q;

  // in_ready comes from registered state only; rst masks it so nothing is
  // taken upstream while reset is held.
  assign bus.in_ready   = (estado == CARGA) && !rst;
  assign bus.mat_valid  = (estado == CHEIO);
  assign bus.matriz_5x5 = mat_q;
  assign aceita         = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= CARGA;
      elem_cnt <= '0;
      mat_q    <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado   <= estado_n;
      elem_cnt <= cnt_n;
      mat_q    <= mat_n;
      erro_q   <= erro_n;
    end
  end

  always_comb begin
    estado_n = estado;
    cnt_n    = elem_cnt;
    mat_n    = mat_q;
    erro_n   = 1'b0;
    if (limpa) begin
      // Abort wins over any accept; matrix contents are left as-is since they
      // are meaningless while mat_valid is low.
      estado_n = CARGA;
      cnt_n    = '0;
    end else begin
      case (estado)
        CARGA: begin
          if (aceita) begin
            mat_n = {mat_q[NELEM*W-W-1:0], bus.in_data};
            if (elem_cnt == ULT) begin
              cnt_n = '0;
`ifdef CARREGADOR_CHECA_LAST_EN
              // Missing last: drop the frame instead of presenting it.
              if (bus.in_last) estado_n = CHEIO;
              else             erro_n   = 1'b1;
`else
              estado_n = CHEIO;
`endif
            end else begin
              cnt_n = elem_cnt + 5'd1;
`ifdef CARREGADOR_CHECA_LAST_EN
              // Early last: restart the frame count.
              if (bus.in_last) begin
                cnt_n  = '0;
                erro_n = 1'b1;
              end
`endif
            end
          end
        end
        CHEIO: begin
          if (bus.mat_ready) estado_n = CARGA;
        end
        default: estado_n = CARGA;
      endcase
    end
  end

`ifdef CARREGADOR_CHECA_LAST_EN
  assign erro_quadro = erro_q;
`else
  assign erro_quadro = 1'b0;
`endif

endmodule
